// File: rtl/dcache_pkg.sv
// Tag store layout and lookup FSM state type for the dcache tag lookup.
package dcache_pkg;

  localparam int unsigned DCACHE_TAG_WIDTH             = 20;
  localparam int unsigned TAG_STORE_DIRTY_BIT_POSITION = DCACHE_TAG_WIDTH;
  localparam int unsigned TAG_STORE_VALID_BIT_POSITION = DCACHE_TAG_WIDTH + 1;

  typedef struct packed {
    logic                        valid;
    logic                        dirty;
    logic [DCACHE_TAG_WIDTH-1:0] tag;
  } tag_store_data_t;

  typedef logic [$bits(tag_store_data_t)-1:0] tag_store_bit_enable_t;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WB_REQ,
    REFILL_REQ,
    REFILL_WAIT,
    TAG_WRITE
  } dcache_state_e;

endpackage

// File: rtl/wt_cache_pkg.sv
// Write-through cache geometry shared by the dcache blocks.
package wt_cache_pkg;

  localparam int unsigned DCACHE_NUM_WORDS = 256;

endpackage

// File: rtl/dcache_tag_lookup.sv
// Single-request dcache tag lookup: tag compare, dirty-victim writeback,
// refill request and final tag store update.
module dcache_tag_lookup
  import dcache_pkg::*;
#(
  parameter int unsigned TAG_WIDTH   = dcache_pkg::DCACHE_TAG_WIDTH,
  parameter int unsigned NUM_WORDS   = wt_cache_pkg::DCACHE_NUM_WORDS,
  localparam int unsigned INDEX_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [INDEX_WIDTH-1:0] req_index_i,
  input  logic [TAG_WIDTH-1:0]   req_tag_i,
  input  logic                   req_we_i,
  output logic                   rsp_valid_o,
  output logic                   rsp_hit_o,
  output logic                   tag_en_o,
  output logic                   tag_we_o,
  output logic [INDEX_WIDTH-1:0] tag_addr_o,
  output tag_store_data_t        tag_wdata_o,
  output tag_store_bit_enable_t  tag_bit_en_o,
  input  tag_store_data_t        tag_rdata_i,
  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [TAG_WIDTH-1:0]   wb_tag_o,
  output logic [INDEX_WIDTH-1:0] wb_index_o,
  output logic                   refill_valid_o,
  input  logic                   refill_ready_i,
  input  logic                   refill_done_i
);

  dcache_state_e          state_q, state_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                   we_q, we_d;
  logic [TAG_WIDTH-1:0]   wb_tag_q, wb_tag_d;
  logic                   line_hit;
  logic                   victim_dirty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      index_q  <= '0;
      tag_q    <= '0;
      we_q     <= 1'b0;
      wb_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      tag_q    <= tag_d;
      we_q     <= we_d;
      wb_tag_q <= wb_tag_d;
    end
  end

  assign line_hit     = tag_rdata_i[TAG_STORE_VALID_BIT_POSITION] && (tag_rdata_i.tag == tag_q);
  assign victim_dirty = tag_rdata_i[TAG_STORE_VALID_BIT_POSITION]
                        && tag_rdata_i[TAG_STORE_DIRTY_BIT_POSITION];

  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    tag_d          = tag_q;
    we_d           = we_q;
    wb_tag_d       = wb_tag_q;
    req_ready_o    = 1'b0;
    rsp_valid_o    = 1'b0;
    rsp_hit_o      = 1'b0;
    tag_en_o       = 1'b0;
    tag_we_o       = 1'b0;
    tag_addr_o     = '0;
    tag_wdata_o    = '0;
    tag_bit_en_o   = '0;
    wb_valid_o     = 1'b0;
    wb_tag_o       = '0;
    wb_index_o     = '0;
    refill_valid_o = 1'b0;

    unique case (state_q)
      // Held in IDLE by reset, so also gate on rst_i to keep every output low while asserted.
      IDLE: begin
        req_ready_o = !rst_i;
        if (req_valid_i && !rst_i) begin
          index_d    = req_index_i;
          tag_d      = req_tag_i;
          we_d       = req_we_i;
          tag_en_o   = 1'b1;
          tag_addr_o = req_index_i;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        if (line_hit) begin
          rsp_valid_o = 1'b1;
          rsp_hit_o   = 1'b1;
          if (we_q) begin
            tag_en_o                                   = 1'b1;
            tag_we_o                                   = 1'b1;
            tag_addr_o                                 = index_q;
            tag_bit_en_o[TAG_STORE_DIRTY_BIT_POSITION] = 1'b1;
            tag_wdata_o.dirty                          = 1'b1;
          end
          state_d = IDLE;
        end else if (victim_dirty) begin
          wb_tag_d = tag_rdata_i.tag;
          state_d  = WB_REQ;
        end else begin
          state_d = REFILL_REQ;
        end
      end
      WB_REQ: begin
        wb_valid_o = 1'b1;
        wb_tag_o   = wb_tag_q;
        wb_index_o = index_q;
        if (wb_ready_i) state_d = REFILL_REQ;
      end
      REFILL_REQ: begin
        refill_valid_o = 1'b1;
        if (refill_ready_i) state_d = REFILL_WAIT;
      end
      REFILL_WAIT: begin
        if (refill_done_i) state_d = TAG_WRITE;
      end
      TAG_WRITE: begin
        tag_en_o          = 1'b1;
        tag_we_o          = 1'b1;
        tag_addr_o        = index_q;
        tag_bit_en_o      = '1;
        tag_wdata_o.valid = 1'b1;
        tag_wdata_o.dirty = we_q;
        tag_wdata_o.tag   = tag_q;
        rsp_valid_o       = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_tag_lookup.sv
// Self-checking bench for dcache_tag_lookup: behavioural tag store plus a
// per-index line model (valid/dirty/tag) predicting hit, writeback and final line.
module tb_dcache_tag_lookup;
  import dcache_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_i;
  logic                  req_valid_i, req_ready_o, req_we_i;
  logic [7:0]            req_index_i;
  logic [19:0]           req_tag_i;
  logic                  rsp_valid_o, rsp_hit_o;
  logic                  tag_en_o, tag_we_o;
  logic [7:0]            tag_addr_o;
  tag_store_data_t       tag_wdata_o, tag_rdata_i;
  tag_store_bit_enable_t tag_bit_en_o;
  logic                  wb_valid_o, wb_ready_i;
  logic [19:0]           wb_tag_o;
  logic [7:0]            wb_index_o;
  logic                  refill_valid_o, refill_ready_i, refill_done_i;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Tag store model, written by the DUT or by bench preloads.
  tag_store_data_t mem [256];
  logic            mem_clr, pre_en;
  logic [7:0]      pre_addr;
  tag_store_data_t pre_data;

  // Line model indexed by low index bits (bench only uses indexes 0..15).
  logic        m_v [16];
  logic        m_d [16];
  logic [19:0] m_t [16];

  logic [6:0] ctl;
  assign ctl = {req_ready_o, tag_en_o, tag_we_o, rsp_valid_o, rsp_hit_o, wb_valid_o, refill_valid_o};

  always #5 clk = ~clk;

  dcache_tag_lookup #(.TAG_WIDTH(20), .NUM_WORDS(256)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_index_i(req_index_i), .req_tag_i(req_tag_i), .req_we_i(req_we_i),
    .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o),
    .tag_en_o(tag_en_o), .tag_we_o(tag_we_o), .tag_addr_o(tag_addr_o),
    .tag_wdata_o(tag_wdata_o), .tag_bit_en_o(tag_bit_en_o), .tag_rdata_i(tag_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_tag_o(wb_tag_o), .wb_index_o(wb_index_o),
    .refill_valid_o(refill_valid_o), .refill_ready_i(refill_ready_i),
    .refill_done_i(refill_done_i)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      tag_rdata_i <= '0;
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end else if (tag_en_o && tag_we_o) begin
      mem[tag_addr_o] <= (mem[tag_addr_o] & ~tag_bit_en_o) | (tag_wdata_o & tag_bit_en_o);
    end else if (tag_en_o) begin
      tag_rdata_i <= mem[tag_addr_o];
    end
  end

  task automatic preload(input logic [7:0] idx, input logic v, input logic d, input logic [19:0] tg);
    pre_en = 1'b1; pre_addr = idx; pre_data = '{valid: v, dirty: d, tag: tg};
    @(posedge clk); #1;
    pre_en = 1'b0;
    m_v[idx[3:0]] = v; m_d[idx[3:0]] = d; m_t[idx[3:0]] = tg;
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic do_txn(input logic [7:0] idx, input logic [19:0] tg, input logic we,
                        input int unsigned wb_dly, input int unsigned rq_dly, input int unsigned dn_dly);
    logic                  hit, need_wb;
    logic [19:0]           vtag;
    logic [6:0]            exp_ctl;
    tag_store_bit_enable_t dirty_only;
    tag_store_data_t       exp_line;
    hit        = m_v[idx[3:0]] && (m_t[idx[3:0]] == tg);
    need_wb    = !hit && m_v[idx[3:0]] && m_d[idx[3:0]];
    vtag       = m_t[idx[3:0]];
    dirty_only = tag_store_bit_enable_t'(1) << TAG_STORE_DIRTY_BIT_POSITION;

    req_valid_i = 1'b1; req_index_i = idx; req_tag_i = tg; req_we_i = we;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b1100000 || tag_addr_o !== idx) begin
      miscompares++;
      $display("FAIL accept idx=%0d: ctl=%b addr=%0d, required ctl=1100000 addr=%0d", idx, ctl, tag_addr_o, idx);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    exp_ctl = !hit ? 7'b0000000 : (we ? 7'b0111100 : 7'b0001100);
    vectors++;
    if (ctl !== exp_ctl) begin
      miscompares++;
      $display("FAIL compare idx=%0d tag=%h we=%0d: ctl=%b, required %b", idx, tg, we, ctl, exp_ctl);
    end
    if (hit && we) begin
      vectors++;
      if (tag_bit_en_o !== dirty_only || tag_wdata_o.dirty !== 1'b1 || tag_addr_o !== idx) begin
        miscompares++;
        $display("FAIL store_hit_write: bit_en=%h dirty=%b addr=%0d, required bit_en=%h dirty=1 addr=%0d",
                 tag_bit_en_o, tag_wdata_o.dirty, tag_addr_o, dirty_only, idx);
      end
    end

    if (!hit) begin
      if (need_wb) begin
        for (int i = 0; i <= int'(wb_dly); i++) begin
          @(posedge clk); #1;
          wb_ready_i = (i == int'(wb_dly));
          @(negedge clk);
          vectors++;
          if (ctl !== 7'b0000010 || wb_tag_o !== vtag || wb_index_o !== idx) begin
            miscompares++;
            $display("FAIL wb_req cyc%0d: ctl=%b wb_tag=%h wb_index=%0d, required ctl=0000010 wb_tag=%h wb_index=%0d",
                     i, ctl, wb_tag_o, wb_index_o, vtag, idx);
          end
        end
      end
      for (int i = 0; i <= int'(rq_dly); i++) begin
        @(posedge clk); #1;
        wb_ready_i     = 1'b0;
        refill_ready_i = (i == int'(rq_dly));
        @(negedge clk);
        vectors++;
        if (ctl !== 7'b0000001) begin
          miscompares++;
          $display("FAIL refill_req cyc%0d: ctl=%b, required 0000001", i, ctl);
        end
      end
      for (int i = 0; i <= int'(dn_dly); i++) begin
        @(posedge clk); #1;
        refill_ready_i = 1'b0;
        refill_done_i  = (i == int'(dn_dly));
        @(negedge clk);
        vectors++;
        if (ctl !== 7'b0000000) begin
          miscompares++;
          $display("FAIL refill_wait cyc%0d: ctl=%b, required 0000000", i, ctl);
        end
      end
      @(posedge clk); #1;
      refill_done_i = 1'b0;
      exp_line = '{valid: 1'b1, dirty: we, tag: tg};
      @(negedge clk);
      vectors++;
      if (ctl !== 7'b0111000 || tag_bit_en_o !== '1 || tag_wdata_o !== exp_line || tag_addr_o !== idx) begin
        miscompares++;
        $display("FAIL tag_write: ctl=%b bit_en=%h wdata=%h addr=%0d, required ctl=0111000 bit_en=all wdata=%h addr=%0d",
                 ctl, tag_bit_en_o, tag_wdata_o, tag_addr_o, exp_line, idx);
      end
      m_v[idx[3:0]] = 1'b1; m_d[idx[3:0]] = we; m_t[idx[3:0]] = tg;
    end else if (we) begin
      m_d[idx[3:0]] = 1'b1;
    end

    @(posedge clk); #1;
    exp_line = '{valid: m_v[idx[3:0]], dirty: m_d[idx[3:0]], tag: m_t[idx[3:0]]};
    vectors++;
    if (mem[idx] !== exp_line || ctl !== 7'b1000000) begin
      miscompares++;
      $display("FAIL line_after idx=%0d: line=%h ctl=%b, required line=%h ctl=1000000", idx, mem[idx], ctl, exp_line);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; mem_clr = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    req_valid_i = 1'b0; req_index_i = '0; req_tag_i = '0; req_we_i = 1'b0;
    wb_ready_i = 1'b0; refill_ready_i = 1'b0; refill_done_i = 1'b0;
    for (int i = 0; i < 16; i++) begin m_v[i] = 1'b0; m_d[i] = 1'b0; m_t[i] = '0; end
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++;
      $display("FAIL in_reset: ctl=%b, required 0000000", ctl);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b1000000 || wb_tag_o !== '0 || wb_index_o !== '0 || tag_addr_o !== '0
        || tag_wdata_o !== '0 || tag_bit_en_o !== '0) begin
      miscompares++;
      $display("FAIL after_reset: ctl=%b wb_tag=%h wb_index=%0d addr=%0d wdata=%h bit_en=%h, required ctl=1000000 rest 0",
               ctl, wb_tag_o, wb_index_o, tag_addr_o, tag_wdata_o, tag_bit_en_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    preload(8'd5, 1'b1, 1'b0, 20'h12);
    do_txn(8'd5, 20'h12, 1'b0, 0, 0, 0);
    do_txn(8'd5, 20'h12, 1'b1, 0, 0, 0);
    vectors++;
    if (mem[5].dirty !== 1'b1 || mem[5].tag !== 20'h12) begin
      miscompares++;
      $display("FAIL store_hit_line: dirty=%b tag=%h, required dirty=1 tag=12", mem[5].dirty, mem[5].tag);
    end
    do_txn(8'd5, 20'h34, 1'b0, 3, 1, 2);
    vectors++;
    if (mem[5] !== tag_store_data_t'({1'b1, 1'b0, 20'h34})) begin
      miscompares++;
      $display("FAIL dirty_miss_line: line=%h, required valid=1 dirty=0 tag=34", mem[5]);
    end
    preload(8'd6, 1'b1, 1'b0, 20'h21);
    do_txn(8'd6, 20'h22, 1'b1, 0, 0, 1);
  endtask

  task automatic test_back_to_back;
    preload(8'd3, 1'b1, 1'b1, 20'h77);
    req_valid_i = 1'b1; req_index_i = 8'd3; req_tag_i = 20'h77; req_we_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b0001100) begin
      miscompares++;
      $display("FAIL b2b_rsp_cycle: ctl=%b, required 0001100", ctl);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b1100000) begin
      miscompares++;
      $display("FAIL b2b_accept: ctl=%b, required 1100000", ctl);
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b0001100) begin
      miscompares++;
      $display("FAIL b2b_second_rsp: ctl=%b, required 0001100", ctl);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_refill;
    preload(8'd9, 1'b0, 1'b0, 20'h0);
    req_valid_i = 1'b1; req_index_i = 8'd9; req_tag_i = 20'h55; req_we_i = 1'b1;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    refill_ready_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b0000001) begin
      miscompares++;
      $display("FAIL pre_abort_refill: ctl=%b, required 0000001", ctl);
    end
    @(posedge clk); #1;
    refill_ready_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    vectors++;
    if (ctl !== 7'b0000000) begin
      miscompares++;
      $display("FAIL reset_in_wait: ctl=%b, required 0000000", ctl);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    refill_done_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b1000000) begin
      miscompares++;
      $display("FAIL stray_done: ctl=%b, required 1000000", ctl);
    end
    @(posedge clk); #1;
    refill_done_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctl !== 7'b1000000 || mem[9] !== '0) begin
      miscompares++;
      $display("FAIL after_abort: ctl=%b line=%h, required ctl=1000000 line=0", ctl, mem[9]);
    end
    @(posedge clk); #1;
    do_txn(8'd9, 20'h55, 1'b0, 0, 0, 0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 150; n++) begin
      do_txn(8'($urandom_range(0, 15)), 20'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_refill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache_tag_lookup.md
DCACHE_TAG_LOOKUP -- requirements
Module: dcache_tag_lookup

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default dcache_pkg::DCACHE_TAG_WIDTH, tag bits per line.
REQ-002 SHALL have parameter NUM_WORDS, default wt_cache_pkg::DCACHE_NUM_WORDS, number of cache indexes; INDEX_WIDTH = $clog2(NUM_WORDS).
REQ-003 SHALL have ports, in this order:
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  lookup request.
- req_ready_o  out  1  request accepted when valid&ready.
- req_index_i  in  INDEX_WIDTH  line index.
- req_tag_i  in  TAG_WIDTH  address tag.
- req_we_i  in  1  1=store, 0=load.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_hit_o  out  1  1=hit, 0=serviced miss; valid with rsp_valid_o.
- tag_en_o / tag_we_o  out  1 each  tag store enable / write enable.
- tag_addr_o  out  INDEX_WIDTH  tag store index.
- tag_wdata_o / tag_bit_en_o  out  tag_store_data_t / tag_store_bit_enable_t  write data, per-bit enable.
- tag_rdata_i  in  tag_store_data_t  tag store read data.
- wb_valid_o  out  1 / wb_ready_i  in  1  writeback request handshake.
- wb_tag_o  out  TAG_WIDTH / wb_index_o  out  INDEX_WIDTH  victim line address.
- refill_valid_o  out  1 / refill_ready_i  in  1  refill request handshake.
- refill_done_i  in  1  one-cycle pulse: line data refilled.

Function
REQ-004 SHALL implement FSM states IDLE, COMPARE, WB_REQ, REFILL_REQ, REFILL_WAIT, TAG_WRITE.
REQ-005 req_ready_o SHALL be 1 only in IDLE; acceptance latches index, tag, we into registers.
REQ-006 In the accept cycle: tag_en_o=1, tag_we_o=0, tag_addr_o=req_index_i; next state COMPARE.
REQ-007 COMPARE: tag_en_o=0 (read data held); hit = rdata valid bit & (rdata tag field == latched tag).
REQ-008 Hit: rsp_valid_o=1, rsp_hit_o=1 in the COMPARE cycle (latency 1 cycle after accept); return to IDLE.
REQ-009 Store hit: same COMPARE cycle tag_en_o=1, tag_we_o=1, tag_bit_en_o only at TAG_STORE_DIRTY_BIT_POSITION, dirty wdata=1.
REQ-010 Miss with victim valid&dirty: next WB_REQ, wb_tag_o/wb_index_o = victim tag/latched index, registered.
REQ-011 Miss otherwise: next REFILL_REQ.
REQ-012 WB_REQ: wb_valid_o=1, outputs stable until wb_ready_i; on handshake go REFILL_REQ.
REQ-013 REFILL_REQ: refill_valid_o=1 until refill_ready_i; then REFILL_WAIT.
REQ-014 REFILL_WAIT: on refill_done_i go TAG_WRITE; refill_done_i outside REFILL_WAIT SHALL be ignored.
REQ-015 TAG_WRITE: full-line write (all bit_en=1): valid=1, dirty=latched we, tag=latched tag; rsp_valid_o=1, rsp_hit_o=0; next IDLE.
REQ-016 A request presented on the cycle rsp_valid_o fires SHALL NOT be accepted (ready=0); accepted next cycle.
REQ-017 All outputs not explicitly driven in a state SHALL be 0.

Reset
REQ-018 rst_i SHALL asynchronously force IDLE and clear latched registers; every output 0 except req_ready_o=1 after deassertion.
REQ-019 Reset mid-miss SHALL drop wb_valid_o/refill_valid_o immediately; no response for the aborted request.

Structure
REQ-020 State enum, tag_store_data_t, tag_store_bit_enable_t, DCACHE_TAG_WIDTH, valid/dirty bit positions SHALL live in dcache_pkg.
REQ-021 Single module; tag compare inline, no sub-module.

Verification
REQ-022 Post-reset load to index 5, store line valid tag 0x12 -> rsp_valid_o cycle after accept, rsp_hit_o=1, no tag write.
REQ-023 Store hit index 5 tag 0x12 -> COMPARE-cycle write, bit_en only dirty bit; reread shows dirty=1, tag 0x12.
REQ-024 Load to index 5 tag 0x34, victim dirty -> wb_valid_o with wb_tag_o=0x12, held 3 cycles of wb_ready_i=0; then refill; after refill_done_i tag 0x34 valid, dirty=0, rsp_hit_o=0.
REQ-025 Clean-victim miss -> no wb_valid_o; refill_valid_o directly after COMPARE.
REQ-026 rst_i asserted in REFILL_WAIT -> outputs 0 same cycle; stray refill_done_i afterwards ignored; next request serviced normally.
